maint_sequencer: RTL and testbench

// - Responder end of the maintenance request/ack handshake: arbitrates the DDR command path between

---
 rtl/maint_sequencer.sv | 173 +++++++++++++++++
 tb/tb_maint_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maint_sequencer.sv
// rtl/maint_sequencer.sv - Arbitrates the DDR command path between host programs and maintenance routines,
// fetching routine instructions from the maintenance ROM into a small buffer for the executor.
module maint_sequencer #(
    parameter int          INSTR_WIDTH = 64,
    parameter int          ADDR_WIDTH  = 10,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          OPC_MSB     = 63,
    parameter logic [3:0]  END_OPCODE  = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_calib_complete,
    input  logic                   maint_req,
    input  logic                   maint_process,
    output logic                   maint_ack,
    output logic                   softmc_fin,
    output logic [ADDR_WIDTH-1:0]  fetch_addr,
    output logic                   fetch_valid,
    input  logic [INSTR_WIDTH-1:0] maint_instr,
    input  logic                   maint_instr_valid,
    input  logic                   prog_req,
    output logic                   program_process,
    input  logic                   prog_done,
    output logic [INSTR_WIDTH-1:0] exe_instr,
    output logic                   exe_valid,
    input  logic                   exe_ready,
    input  logic                   exe_idle,
    output logic                   maint_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_FETCH, S_DRAIN, S_FIN, S_PROG
    } state_t;

    state_t                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    inflight_q, inflight_d;
    logic                    end_seen_q, end_seen_d;
    logic                    err_q, err_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [INSTR_WIDTH-1:0]  mem_q [FIFO_DEPTH];

    logic [CW:0] occupancy;
    logic        fetch_go;
    logic        ret_ok;
    logic        is_end;
    logic        push;
    logic        pop;

    // A strobe reserves a slot until its data lands, so in-flight fetches count toward occupancy.
    always_comb begin
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        fetch_go  = (state_q == S_FETCH) && !end_seen_q && (occupancy < DEPTH_V);
        ret_ok    = inflight_q && maint_instr_valid && !end_seen_q;
        is_end    = (maint_instr[OPC_MSB -: 4] == END_OPCODE);
        push      = ret_ok && !is_end;
        pop       = (count_q != '0) && exe_ready;
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        addr_d     = addr_q;
        inflight_d = fetch_go;
        end_seen_d = end_seen_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (init_calib_complete) begin
                    if (maint_req) begin
                        state_d = S_GRANT;
                        ack_d   = 1'b1;
                    end else if (prog_req) begin
                        state_d = S_PROG;
                    end
                end
            end
            S_GRANT: begin
                if (maint_process) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end else if (!maint_req) begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (ret_ok && is_end) begin
                    end_seen_d = 1'b1;
                end
                if (fetch_go) begin
                    addr_d = addr_q + 1'b1;
                    // Last address strobed without an END: the routine can never terminate cleanly.
                    if (&addr_q && !(ret_ok && is_end)) begin
                        err_d      = 1'b1;
                        end_seen_d = 1'b1;
                    end
                end
                if (end_seen_q && !inflight_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((count_q == '0) && exe_idle) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d    = S_IDLE;
                end_seen_d = 1'b0;
                addr_d     = '0;
            end
            S_PROG: begin
                if (prog_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ack_q      <= 1'b0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            end_seen_q <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            end_seen_q <= end_seen_d;
            err_q      <= err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= maint_instr;
        end
    end

    assign maint_ack       = ack_q;
    assign softmc_fin      = (state_q == S_FIN);
    assign fetch_addr      = addr_q;
    assign fetch_valid     = fetch_go;
    assign program_process = (state_q == S_PROG);
    assign exe_valid       = (count_q != '0);
    assign exe_instr       = mem_q[rd_ptr_q];
    assign maint_err       = err_q;

endmodule

// File: tb/tb_maint_sequencer.sv
// tb/tb_maint_sequencer.sv - Directed vector bench for maint_sequencer with a one-cycle-latency ROM model.
module tb_maint_sequencer;
    localparam int IW = 64;
    localparam int AW = 4;
    localparam logic [IW-1:0] I_A   = 64'h1000_0000_0000_000A;
    localparam logic [IW-1:0] I_B   = 64'h2000_0000_0000_000B;
    localparam logic [IW-1:0] I_C   = 64'h3000_0000_0000_000C;
    localparam logic [IW-1:0] I_END = 64'hF000_0000_0000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_calib_complete = 1'b0;
    logic          maint_req = 1'b0;
    logic          maint_process = 1'b0;
    logic          maint_ack;
    logic          softmc_fin;
    logic [AW-1:0] fetch_addr;
    logic          fetch_valid;
    logic [IW-1:0] maint_instr = '0;
    logic          maint_instr_valid = 1'b0;
    logic          prog_req = 1'b0;
    logic          program_process;
    logic          prog_done = 1'b0;
    logic [IW-1:0] exe_instr;
    logic          exe_valid;
    logic          exe_ready = 1'b1;
    logic          exe_idle = 1'b1;
    logic          maint_err;

    maint_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .maint_req(maint_req), .maint_process(maint_process), .maint_ack(maint_ack),
        .softmc_fin(softmc_fin), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
        .maint_instr(maint_instr), .maint_instr_valid(maint_instr_valid),
        .prog_req(prog_req), .program_process(program_process), .prog_done(prog_done),
        .exe_instr(exe_instr), .exe_valid(exe_valid), .exe_ready(exe_ready),
        .exe_idle(exe_idle), .maint_err(maint_err)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] rom [16];
    always @(posedge clk) begin
        maint_instr_valid <= fetch_valid;
        maint_instr       <= rom[fetch_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          req;
        logic          proc;
        logic          ack;
        logic          fin;
        logic          fv;
        logic [AW-1:0] addr;
        logic          pp;
        logic          ev;
        logic [IW-1:0] instr;
    } vec_t;

    function automatic vec_t mk(input logic req, input logic proc, input logic ack, input logic fin,
                                input logic fv, input int addr, input logic pp, input logic ev,
                                input logic [IW-1:0] instr);
        vec_t v;
        v.req = req; v.proc = proc; v.ack = ack; v.fin = fin; v.fv = fv;
        v.addr = AW'(addr); v.pp = pp; v.ev = ev; v.instr = instr;
        return v;
    endfunction

    vec_t          vt [14];
    logic [IW-1:0] got_q [$];
    int            fin_cnt;
    int            bad_pp;
    int            first_fa;

    // Samples first, then advances; stops a few cycles after the first fin pulse or at the bound.
    task automatic watch(input int max_cyc);
        int post;
        post = 0;
        fin_cnt = 0;
        bad_pp = 0;
        first_fa = -1;
        got_q.delete();
        for (int c = 0; c < max_cyc; c++) begin
            if (exe_valid && exe_ready) got_q.push_back(exe_instr);
            if (fetch_valid && first_fa < 0) first_fa = int'(fetch_addr);
            if (program_process && fin_cnt == 0) bad_pp++;
            if (softmc_fin) begin
                fin_cnt++;
                if (post == 0) post = 3;
            end
            if (post > 0) begin
                post--;
                if (post == 0) break;
            end
            @(negedge clk);
        end
    endtask

    task automatic grant(input string tag);
        bit seen;
        seen = 0;
        maint_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (maint_ack) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_ack"}, seen, 1'b1);
        maint_req = 1'b0;
        maint_process = 1'b1;
        @(negedge clk);
        maint_process = 1'b0;
        chk({tag, "_fetch_start"}, {fetch_valid, fetch_addr}, {1'b1, AW'(0)});
    endtask

    initial begin
        int n;
        bit seen;

        for (int i = 0; i < 16; i++) rom[i] = I_END;
        rom[0] = I_A; rom[1] = I_B; rom[2] = I_C;

        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, '0);
        vt[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, '0);
        vt[2]  = mk(1, 0, 1, 0, 0, 0, 0, 0, '0);
        vt[3]  = mk(1, 1, 0, 0, 0, 0, 0, 0, '0);
        vt[4]  = mk(0, 0, 0, 0, 1, 0, 0, 0, '0);
        vt[5]  = mk(0, 0, 0, 0, 1, 1, 0, 0, '0);
        vt[6]  = mk(0, 0, 0, 0, 1, 2, 0, 1, I_A);
        vt[7]  = mk(0, 0, 0, 0, 1, 3, 0, 1, I_B);
        vt[8]  = mk(0, 0, 0, 0, 1, 4, 0, 1, I_C);
        vt[9]  = mk(0, 0, 0, 0, 0, 5, 0, 0, '0);
        vt[10] = mk(0, 0, 0, 0, 0, 5, 0, 0, '0);
        vt[11] = mk(0, 0, 0, 0, 0, 5, 0, 0, '0);
        vt[12] = mk(0, 0, 0, 1, 0, 5, 0, 0, '0);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, '0);

        rst = 1'b1;
        init_calib_complete = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Basic routine {A,B,C,END}, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_ack", i), maint_ack, vt[i].ack);
            chk($sformatf("v%0d_fin", i), softmc_fin, vt[i].fin);
            chk($sformatf("v%0d_fv", i), fetch_valid, vt[i].fv);
            chk($sformatf("v%0d_addr", i), fetch_addr, vt[i].addr);
            chk($sformatf("v%0d_pp", i), program_process, vt[i].pp);
            chk($sformatf("v%0d_ev", i), exe_valid, vt[i].ev);
            if (vt[i].ev) chk($sformatf("v%0d_instr", i), exe_instr, vt[i].instr);
            chk($sformatf("v%0d_err", i), maint_err, 1'b0);
            maint_req = vt[i].req;
            maint_process = vt[i].proc;
        end

        // Backpressure: buffer fills, fetching stalls at addr 4, resumes on release.
        for (int i = 0; i < 8; i++) rom[i] = {4'h1, 60'(i)};
        rom[8] = I_END;
        exe_ready = 1'b0;
        grant("bp");
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 4 && fetch_valid) n++;
        end
        chk("bp_stall_fv", n, 0);
        chk("bp_stall_addr", fetch_addr, AW'(4));
        chk("bp_head", {exe_valid, exe_instr}, {1'b1, rom[0]});
        exe_ready = 1'b1;
        watch(60);
        chk("bp_resume_addr", first_fa, 4);
        chk("bp_npops", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            chk($sformatf("bp_pop%0d", i), got_q[i], rom[i]);
        chk("bp_fin", fin_cnt, 1);
        chk("bp_empty", exe_valid, 1'b0);

        // Tie: maintenance wins; program gets the path only after fin.
        rom[0] = I_A; rom[1] = I_B; rom[2] = I_C; rom[3] = I_END;
        prog_req = 1'b1;
        grant("tie");
        watch(40);
        chk("tie_pp_during", bad_pp, 0);
        chk("tie_fin", fin_cnt, 1);
        chk("tie_npops", got_q.size(), 3);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (program_process) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("tie_pp_after", seen, 1'b1);
        prog_req = 1'b0;
        prog_done = 1'b1;
        @(negedge clk);
        prog_done = 1'b0;
        chk("tie_pp_drop", program_process, 1'b0);

        // Program first; a later maint_req waits for prog_done.
        prog_req = 1'b1;
        @(negedge clk);
        chk("pf_pp", program_process, 1'b1);
        prog_req = 1'b0;
        maint_req = 1'b1;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!program_process || maint_ack || softmc_fin) n++;
        end
        chk("pf_no_preempt", n, 0);
        prog_done = 1'b1;
        @(negedge clk);
        prog_done = 1'b0;
        chk("pf_release", {program_process, maint_ack}, 2'b00);
        @(negedge clk);
        chk("pf_ack", maint_ack, 1'b1);
        maint_req = 1'b0;
        maint_process = 1'b1;
        @(negedge clk);
        maint_process = 1'b0;
        watch(40);
        chk("pf_fin", fin_cnt, 1);

        // No grant before calibration completes.
        init_calib_complete = 1'b0;
        maint_req = 1'b1;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (maint_ack) n++;
        end
        chk("nocal_ack", n, 0);
        maint_req = 1'b0;
        init_calib_complete = 1'b1;
        @(negedge clk);

        // Overrun: ROM without END on a 4-bit address space.
        for (int i = 0; i < 16; i++) rom[i] = {4'h2, 60'(i)};
        grant("ovr");
        watch(80);
        chk("ovr_err", maint_err, 1'b1);
        chk("ovr_fin", fin_cnt, 1);
        chk("ovr_npops", got_q.size(), 15);
        if (got_q.size() == 15) chk("ovr_last", got_q[14], rom[14]);
        @(negedge clk);
        chk("ovr_sticky", maint_err, 1'b1);

        // Reset in the middle of a routine.
        rom[0] = I_A; rom[1] = I_B; rom[2] = I_C; rom[3] = I_END;
        exe_ready = 1'b0;
        grant("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outs", {maint_ack, softmc_fin, fetch_valid, program_process, exe_valid, maint_err},
            6'b0);
        chk("rst_addr", fetch_addr, AW'(0));
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (softmc_fin || fetch_valid || exe_valid) n++;
        end
        chk("rst_quiet", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
